// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Defaults assume a 100 MHz clock.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    REL_WAIT
  } btn_state_e;

  // 10 ms debounce, 500 ms hold before auto-repeat, 200 ms repeat period
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned HOLD_CYCLES_DEF     = 50_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF   = 20_000_000;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchroniser bringing the raw asynchronous button into the clk domain.
module btn_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the same pre-edge values; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchroniser, symmetric debounce, optional hold-to-repeat.
// Auto-repeat is built only when the macro BTN_AUTOREPEAT_EN is defined.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_repeat
);

  localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam int          CW      = $clog2(CNT_MAX);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t REP_LAST  = cnt_t'(REPEAT_CYCLES - 1);
`endif

  logic       w_btn_s;
  btn_state_e r_state, w_state_nxt;
  cnt_t       r_cnt, w_cnt_nxt;
  logic       r_level, w_level_nxt;
  logic       r_pulse, w_pulse_nxt;
`ifdef BTN_AUTOREPEAT_EN
  logic       r_repeat, w_repeat_nxt;
`endif

  btn_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (btn_in),
    .o_q (w_btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_pulse  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      r_repeat <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_level  <= w_level_nxt;
      r_pulse  <= w_pulse_nxt;
`ifdef BTN_AUTOREPEAT_EN
      r_repeat <= w_repeat_nxt;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_level_nxt  = r_level;
    w_pulse_nxt  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    w_repeat_nxt = r_repeat;
`endif

    case (r_state)
      IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!w_btn_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // Without auto-repeat the counter idles at zero here until release.
      HELD: begin
        if (!w_btn_s) begin
          w_state_nxt = REL_WAIT;
          w_cnt_nxt   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (r_cnt == HOLD_LAST) begin
          w_state_nxt  = REPEAT;
          w_cnt_nxt    = '0;
          w_pulse_nxt  = 1'b1;
          w_repeat_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end

`ifdef BTN_AUTOREPEAT_EN
      REPEAT: begin
        if (!w_btn_s) begin
          w_state_nxt  = REL_WAIT;
          w_cnt_nxt    = '0;
          w_repeat_nxt = 1'b0;
        end else if (r_cnt == REP_LAST) begin
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif

      // A re-press during release debounce is bounce: back to HELD, no pulse.
      REL_WAIT: begin
        if (w_btn_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign btn_level  = r_level;
  assign btn_pulse  = r_pulse;
`ifdef BTN_AUTOREPEAT_EN
  assign btn_repeat = r_repeat;
`else
  assign btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner with short debounce/hold/repeat.
// Expectations follow the build: repeat pulses only when BTN_AUTOREPEAT_EN is defined.
module tb_btn_conditioner;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic btn_pulse;
  logic btn_repeat;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive btn_in for one edge (edge k samples it), then check outputs 1 time unit later.
  task automatic step(input logic b, input logic ep, input logic el, input logic er,
                      input string tag);
    btn_in = b;
    @(posedge clk);
    #1;
    check({tag, " pulse"},  btn_pulse,  ep);
    check({tag, " level"},  btn_level,  el);
    check({tag, " repeat"}, btn_repeat, er);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset pulse",  btn_pulse,  1'b0);
    check("reset level",  btn_level,  1'b0);
    check("reset repeat", btn_repeat, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("idle k=%0d", k));

    // Held 30 cycles: press pulse at 6, repeats from 16 every 3 edges, release r=30.
    for (int k = 0; k <= 40; k++)
      step(k < 30,
           (k == 6) || (AR && k >= 16 && k <= 31 && ((k - 16) % 3 == 0)),
           k >= 6 && k < 36,
           AR && k >= 16 && k <= 31,
           $sformatf("t1 k=%0d", k));

    // Glitch shorter than the debounce window.
    for (int k = 0; k <= 12; k++)
      step(k < 3, 1'b0, 1'b0, 1'b0, $sformatf("t2 k=%0d", k));

    // Release bounce at 12..13 re-enters HELD at 16; hold timer restarts -> repeat at 26.
    for (int k = 0; k <= 40; k++)
      step(k <= 30 && k != 12 && k != 13,
           (k == 6) || (AR && (k == 26 || k == 29 || k == 32)),
           k >= 6 && k < 37,
           AR && k >= 26 && k <= 32,
           $sformatf("t3 k=%0d", k));

    // Reset while held (in REPEAT when auto-repeat is built).
    for (int k = 0; k <= 19; k++)
      step(1'b1,
           (k == 6) || (AR && (k == 16 || k == 19)),
           k >= 6,
           AR && k >= 16,
           $sformatf("t5 pre k=%0d", k));
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, "t5 rst");
    rst = 1'b0;
    for (int k = 0; k <= 9; k++)
      step(1'b1, k == 6, k >= 6, 1'b0, $sformatf("t5 post k=%0d", k));
    for (int k = 0; k <= 9; k++)
      step(1'b0, 1'b0, k < 6, 1'b0, $sformatf("t5 rel k=%0d", k));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

- Converts one raw, asynchronous push-button input into a clean level and single-cycle action pulses for the clock-setting logic.
- Pipeline: two-flop synchroniser, symmetric debounce, then an optional hold-to-auto-repeat stage.
- Sits directly upstream of the hour/minute increment inputs of the digital clock. One instance per button replaces the separate debounce and edge-detect logic.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: input must stay stable for this many cycles before a press or release is accepted; legal range ≥2.
- HOLD_CYCLES, 50_000_000: cycles held after the press pulse before the first repeat pulse; legal range ≥2.
- REPEAT_CYCLES, 20_000_000: period between subsequent repeat pulses; legal range ≥2.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  1  raw asynchronous button; high means pressed.
- btn_level  out  1  debounced button state.
- btn_pulse  out  1  one-cycle strobe: one on accepted press, plus one per auto-repeat.
- btn_repeat  out  1  high while in the auto-repeat phase.

## Operation
**Synchroniser**
- btn_in passes through two flops to give btn_s; both flops reset to 0.

**Counter**
- A single counter cnt, wide enough for the maximum of the three parameters.
- cnt clears on every state change.

**States** (transitions are evaluated on every clock edge):
- **IDLE**
  - btn_s=1 → PRESS_WAIT.
- **PRESS_WAIT**
  - btn_s=0 → IDLE; no output.
  - Otherwise cnt++.
  - When cnt==DEBOUNCE_CYCLES-1 and btn_s=1 → HELD; btn_level←1; btn_pulse for one cycle.
- **HELD**
  - btn_s=0 → REL_WAIT.
  - Otherwise cnt++.
  - When cnt==HOLD_CYCLES-1 → REPEAT; btn_pulse; btn_repeat←1.
- **REPEAT**
  - btn_s=0 → REL_WAIT; btn_repeat←0.
  - Otherwise cnt++.
  - When cnt==REPEAT_CYCLES-1: btn_pulse; cnt←0.
- **REL_WAIT**
  - btn_level stays 1.
  - btn_s=1 → HELD with cnt=0, with no pulse; this is release bounce.
  - Otherwise cnt++.
  - When cnt==DEBOUNCE_CYCLES-1 → IDLE; btn_level←0.

**Outputs**
- All outputs are registered; there are no combinational paths from btn_in.
- btn_pulse is never high for two consecutive cycles, because all parameters are ≥2.

## Timing
- **Reset:**
  - state=IDLE, cnt=0, sync flops=0.
  - btn_level=0, btn_pulse=0, btn_repeat=0 from the cycle after the reset edge.
- **Reset mid-operation:**
  - Any state returns to IDLE and all outputs go to 0 immediately.
  - A button still held after reset is treated as a new press: a full debounce, then one pulse.
- **Press latency:**
  - Let edge 0 be the first edge that samples btn_in=1.
  - btn_pulse and btn_level rise after edge DEBOUNCE_CYCLES+2, provided btn_in is stable.
- **Release latency:** symmetric; btn_level falls after edge DEBOUNCE_CYCLES+2, counted from the first edge sampling btn_in=0.
- **Auto-repeat cadence:**
  - First repeat pulse comes HOLD_CYCLES edges after the press pulse.
  - Subsequent repeat pulses come every REPEAT_CYCLES edges.
- **Glitches:** a high glitch shorter than DEBOUNCE_CYCLES produces no level change and no pulse.

## Configuration
- **BTN_AUTOREPEAT_EN defined:**
  - The HELD→REPEAT transition and the REPEAT state are present, as described above.
- **Undefined:**
  - HELD only waits for release.
  - The REPEAT state is not synthesised and btn_repeat is tied to 0.
  - Exactly one btn_pulse per accepted press.
  - HOLD_CYCLES and REPEAT_CYCLES are ignored.

## Structure
- Shared package btn_pkg holds:
  - the state enum (IDLE, PRESS_WAIT, HELD, REPEAT, REL_WAIT);
  - default timing constants for a 100 MHz clock.
- One sub-module, btn_sync2: a parameter-free two-flop synchroniser with synchronous reset.
- The FSM and counter live in btn_conditioner.

## Test plan
Parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, BTN_AUTOREPEAT_EN defined.

1. btn_in high for 30 cycles from edge 0 → btn_pulse high after edges 6, 16, 19, 22, 25, 28, 31 (repeat pulses continue every 3 edges until REL_WAIT is entered at edge 32); btn_level=1 from edge 6; btn_repeat=1 from edge 16 until REL_WAIT is entered.
2. btn_in high for 3 cycles, then low → btn_level and btn_pulse stay 0 throughout.
3. Hold, release for 2 cycles, then re-press with btn_level=1 → no extra pulse; HELD timer restarts; btn_level never drops.
4. Release after a stable hold → btn_level falls after edge r+6, where r is the first edge sampling btn_in=0; no pulse at release.
5. Assert rst for 1 cycle during REPEAT while the button stays held → all outputs 0 next cycle; new press pulse 6 edges after rst deasserts.
6. BTN_AUTOREPEAT_EN undefined, hold for 40 cycles → exactly one btn_pulse (after edge 6); btn_repeat stays 0.
